fir_cfg_ctrl: RTL and testbench

- Configuration sequencer in front of the FIR compensator. Loads a new coefficient set into the filter's coefficient RAM through a valid/ready stream.
- During a reload it blocks the sample path and then flushes the filter delay line with zeros, so no output mixes old and new taps.
- In normal operation it forwards input samples to the filter with one registered stage.

---
 rtl/fir_cfg_ctrl.sv | 176 +++++++++++++++++
 tb/tb_fir_cfg_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_cfg_ctrl.sv
// Configuration sequencer for the FIR compensator: streams a coefficient set into
// the coefficient RAM, then flushes the delay line with zeros before resuming samples.
module fir_cfg_ctrl #(
    parameter int N_MAX       = 92,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int ADDR_WIDTH  = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic [ADDR_WIDTH-1:0]  cfg_num_taps,
    input  logic                   cfg_abort,
    input  logic [COEFF_WIDTH-1:0] cfg_coeff,
    input  logic                   cfg_coeff_valid,
    output logic                   cfg_coeff_ready,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    output logic                   cfg_err,
    output logic [15:0]            drop_count,
    input  logic                   s_valid_in,
    input  logic [DATA_WIDTH-1:0]  s_data_in,
    output logic                   fir_valid_in,
    output logic [DATA_WIDTH-1:0]  fir_x_input,
    output logic                   coeff_we,
    output logic [ADDR_WIDTH-1:0]  coeff_addr,
    output logic [COEFF_WIDTH-1:0] coeff_wdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FLUSH = 2'd2} state_t;

    localparam logic [ADDR_WIDTH-1:0] MAX_TAPS = ADDR_WIDTH'(N_MAX);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    state_t                 state_r, state_s;
    logic [ADDR_WIDTH-1:0]  num_taps_r, num_taps_s;
    logic [ADDR_WIDTH-1:0]  addr_r, addr_s;
    logic [ADDR_WIDTH-1:0]  flush_cnt_r, flush_cnt_s;
    logic                   done_pend_r, done_pend_s;
    logic                   fir_valid_s, coeff_we_s, done_s, err_s;
    logic [DATA_WIDTH-1:0]  fir_x_s;
    logic [ADDR_WIDTH-1:0]  coeff_addr_s;
    logic [COEFF_WIDTH-1:0] coeff_wdata_s;
    logic [15:0]            drop_s;
    logic                   start_ok_s, hs_s, last_coeff_s, last_flush_s;

    assign cfg_coeff_ready = (state_r == LOAD);
    assign cfg_busy        = (state_r != IDLE);

    assign start_ok_s   = cfg_start && (cfg_num_taps != {ADDR_WIDTH{1'b0}}) && (cfg_num_taps <= MAX_TAPS);
    assign hs_s         = cfg_coeff_valid && (state_r == LOAD);
    assign last_coeff_s = hs_s && (addr_r == (num_taps_r - ONE));
    assign last_flush_s = (state_r == FLUSH) && (flush_cnt_r == (num_taps_r - ONE));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; abort takes priority over the final handshake or flush beat
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) state_s = LOAD;
                else            state_s = IDLE;
            end
            LOAD: begin
                if (cfg_abort)         state_s = IDLE;
                else if (last_coeff_s) state_s = FLUSH;
                else                   state_s = LOAD;
            end
            FLUSH: begin
                if (cfg_abort || last_flush_s) state_s = IDLE;
                else                           state_s = FLUSH;
            end
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs and counters
    always_comb begin
        fir_valid_s   = 1'b0;
        fir_x_s       = fir_x_input;
        coeff_we_s    = 1'b0;
        coeff_addr_s  = coeff_addr;
        coeff_wdata_s = coeff_wdata;
        done_s        = done_pend_r;
        err_s         = 1'b0;
        num_taps_s    = num_taps_r;
        addr_s        = addr_r;
        flush_cnt_s   = flush_cnt_r;
        done_pend_s   = 1'b0;
        if ((state_r != IDLE) && s_valid_in && (drop_count != 16'hFFFF)) begin
            drop_s = drop_count + 16'd1;
        end else begin
            drop_s = drop_count;
        end
        case (state_r)
            IDLE: begin
                fir_valid_s = s_valid_in;
                if (s_valid_in) fir_x_s = s_data_in;
                else            fir_x_s = fir_x_input;
                if (start_ok_s) begin
                    num_taps_s  = cfg_num_taps;
                    drop_s      = 16'd0;
                    addr_s      = {ADDR_WIDTH{1'b0}};
                    flush_cnt_s = {ADDR_WIDTH{1'b0}};
                end else begin
                    err_s = cfg_start;
                end
            end
            LOAD: begin
                if (cfg_abort) begin
                    err_s = 1'b1;
                end else if (hs_s) begin
                    coeff_we_s    = 1'b1;
                    coeff_addr_s  = addr_r;
                    coeff_wdata_s = cfg_coeff;
                    addr_s        = addr_r + ONE;
                end else begin
                    coeff_we_s = 1'b0;
                end
            end
            FLUSH: begin
                if (cfg_abort) begin
                    err_s = 1'b1;
                end else begin
                    fir_valid_s = 1'b1;
                    fir_x_s     = {DATA_WIDTH{1'b0}};
                    flush_cnt_s = flush_cnt_r + ONE;
                    done_pend_s = last_flush_s;
                end
            end
            default: begin
                err_s = 1'b0;
            end
        endcase
    end

    // Output and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fir_valid_in <= 1'b0;
            fir_x_input  <= {DATA_WIDTH{1'b0}};
            coeff_we     <= 1'b0;
            coeff_addr   <= {ADDR_WIDTH{1'b0}};
            coeff_wdata  <= {COEFF_WIDTH{1'b0}};
            cfg_done     <= 1'b0;
            cfg_err      <= 1'b0;
            drop_count   <= 16'd0;
            num_taps_r   <= {ADDR_WIDTH{1'b0}};
            addr_r       <= {ADDR_WIDTH{1'b0}};
            flush_cnt_r  <= {ADDR_WIDTH{1'b0}};
            done_pend_r  <= 1'b0;
        end else begin
            fir_valid_in <= fir_valid_s;
            fir_x_input  <= fir_x_s;
            coeff_we     <= coeff_we_s;
            coeff_addr   <= coeff_addr_s;
            coeff_wdata  <= coeff_wdata_s;
            cfg_done     <= done_s;
            cfg_err      <= err_s;
            drop_count   <= drop_s;
            num_taps_r   <= num_taps_s;
            addr_r       <= addr_s;
            flush_cnt_r  <= flush_cnt_s;
            done_pend_r  <= done_pend_s;
        end
    end

endmodule

// File: tb/tb_fir_cfg_ctrl.sv
// Directed/randomized bench for fir_cfg_ctrl; expectations come from transaction-level
// rules (write list, flush length, drop arithmetic) rather than a cycle model.
module tb_fir_cfg_ctrl;
    localparam int AW = 7;
    localparam int DW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_start = 1'b0;
    logic [AW-1:0] cfg_num_taps = '0;
    logic          cfg_abort = 1'b0;
    logic [CW-1:0] cfg_coeff = '0;
    logic          cfg_coeff_valid = 1'b0;
    logic          cfg_coeff_ready, cfg_busy, cfg_done, cfg_err;
    logic [15:0]   drop_count;
    logic          s_valid_in = 1'b0;
    logic [DW-1:0] s_data_in = '0;
    logic          fir_valid_in, coeff_we;
    logic [DW-1:0] fir_x_input;
    logic [AW-1:0] coeff_addr;
    logic [CW-1:0] coeff_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [AW-1:0] wr_addr_q[$];
    logic [CW-1:0] wr_data_q[$];
    int done_cnt, err_cnt;

    always #5 clk = ~clk;

    fir_cfg_ctrl dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_taps(cfg_num_taps),
        .cfg_abort(cfg_abort), .cfg_coeff(cfg_coeff), .cfg_coeff_valid(cfg_coeff_valid),
        .cfg_coeff_ready(cfg_coeff_ready), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .cfg_err(cfg_err), .drop_count(drop_count), .s_valid_in(s_valid_in),
        .s_data_in(s_data_in), .fir_valid_in(fir_valid_in), .fir_x_input(fir_x_input),
        .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_wdata(coeff_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; observe 1 time unit after the edge and log writes/pulses
    task automatic cyc();
        @(posedge clk);
        #1;
        if (coeff_we === 1'b1) begin
            wr_addr_q.push_back(coeff_addr);
            wr_data_q.push_back(coeff_wdata);
        end
        if (cfg_done === 1'b1) done_cnt++;
        if (cfg_err === 1'b1) err_cnt++;
    endtask

    task automatic pass_through(input int count, input logic [DW-1:0] first);
        logic [DW-1:0] d;
        for (int i = 0; i < count; i++) begin
            d = (i == 0) ? first : DW'($urandom);
            s_valid_in = 1'b1;
            s_data_in  = d;
            cyc();
            chk("pt_valid", fir_valid_in, 1);
            chk("pt_data", fir_x_input, d);
        end
        chk("pt_drop", drop_count, 0);
        s_valid_in = 1'b0;
    endtask

    task automatic reject(input int n);
        logic [DW-1:0] d;
        d = DW'($urandom);
        cfg_start = 1'b1; cfg_num_taps = AW'(n); s_valid_in = 1'b1; s_data_in = d;
        wr_addr_q.delete();
        cyc();
        cfg_start = 1'b0;
        chk("rej_err", cfg_err, 1);
        chk("rej_busy", cfg_busy, 0);
        chk("rej_fwd", fir_x_input, d);
        chk("rej_we", coeff_we, 0);
        d = DW'($urandom);
        s_data_in = d;
        cyc();
        chk("rej_err_pulse", cfg_err, 0);
        chk("rej_fwd2", fir_x_input, d);
        chk("rej_nowrite", wr_addr_q.size(), 0);
        s_valid_in = 1'b0;
    endtask

    // mode: 0 back-to-back, 1 toggle 1/0, 2 three-cycle gap, 3 random valid
    task automatic reload(input int n, input int mode, input int abort_after, input bit sv);
        logic [CW-1:0] coeffs[$];
        logic [DW-1:0] d;
        int  sent, load_cycles;
        bit  v, aborted;
        for (int i = 0; i < n; i++)
            coeffs.push_back((mode == 0) ? CW'((i + 1) * 256) : CW'($urandom));
        wr_addr_q.delete(); wr_data_q.delete();
        done_cnt = 0; err_cnt = 0; aborted = 1'b0;
        d = DW'($urandom);
        cfg_start = 1'b1; cfg_num_taps = AW'(n); s_valid_in = sv; s_data_in = d;
        cyc();
        cfg_start = 1'b0;
        chk("start_busy", cfg_busy, 1);
        chk("start_ready", cfg_coeff_ready, 1);
        chk("start_fwd", fir_valid_in, 32'(sv));
        if (sv) chk("start_fwd_data", fir_x_input, d);
        chk("start_drop_clr", drop_count, 0);
        sent = 0; load_cycles = 0;
        while (sent < n) begin
            if (load_cycles > 4000) begin
                chk("load_timeout", load_cycles, 32'(n));
                break;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (load_cycles % 2) == 0;
                2:       v = !(load_cycles >= 2 && load_cycles < 5);
                default: v = 1'($urandom_range(0, 1));
            endcase
            s_valid_in = sv; s_data_in = DW'($urandom);
            if (abort_after >= 0 && sent == abort_after) begin
                cfg_abort = 1'b1; cfg_coeff_valid = 1'b0;
                cyc();
                cfg_abort = 1'b0;
                load_cycles++;
                aborted = 1'b1;
                break;
            end
            chk("load_ready", cfg_coeff_ready, 1);
            cfg_coeff_valid = v; cfg_coeff = coeffs[sent];
            cyc();
            load_cycles++;
            if (v) sent++;
            chk("load_busy", cfg_busy, 1);
            chk("load_no_sample", fir_valid_in, 0);
        end
        cfg_coeff_valid = 1'b0;
        if (aborted) begin
            chk("abort_err", cfg_err, 1);
            chk("abort_busy", cfg_busy, 0);
            chk("abort_drop", drop_count, sv ? load_cycles : 0);
            d = DW'($urandom);
            s_valid_in = 1'b1; s_data_in = d;
            cyc();
            chk("abort_err_pulse", cfg_err, 0);
            chk("abort_resume", fir_valid_in, 1);
            chk("abort_resume_data", fir_x_input, d);
            chk("abort_no_flush_done", done_cnt, 0);
            chk("abort_writes", wr_addr_q.size(), 32'(abort_after));
        end else begin
            chk("last_we", coeff_we, 1);
            for (int k = 1; k <= n; k++) begin
                s_valid_in = sv; s_data_in = DW'($urandom);
                cyc();
                chk("flush_valid", fir_valid_in, 1);
                chk("flush_zero", fir_x_input, 0);
                chk("flush_no_we", coeff_we, 0);
                chk("flush_ready", cfg_coeff_ready, 0);
                chk("flush_busy", cfg_busy, (k < n) ? 1 : 0);
                chk("flush_no_early_done", done_cnt, 0);
            end
            d = DW'($urandom);
            s_valid_in = sv; s_data_in = d;
            cyc();
            chk("done_pulse", cfg_done, 1);
            chk("done_idle", cfg_busy, 0);
            chk("done_fwd", fir_valid_in, 32'(sv));
            if (sv) chk("done_fwd_data", fir_x_input, d);
            chk("drop_total", drop_count, sv ? (load_cycles + n) : 0);
            s_valid_in = 1'b0;
            cyc();
            chk("done_once", done_cnt, 1);
            chk("no_err", err_cnt, 0);
        end
        s_valid_in = 1'b0;
        for (int i = 0; i < wr_addr_q.size() && i < n; i++) begin
            chk("wr_addr", wr_addr_q[i], i);
            chk("wr_data", wr_data_q[i], coeffs[i]);
        end
        if (!aborted) chk("wr_count", wr_addr_q.size(), n);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", cfg_busy, 0);
        chk("rst_ready", cfg_coeff_ready, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_fir_valid", fir_valid_in, 0);
        chk("rst_we", coeff_we, 0);
        chk("rst_done_err", {cfg_done, cfg_err}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        pass_through(128, 16'h4000);
        cyc();
        chk("hold_valid", fir_valid_in, 0);
        chk("hold_data", fir_x_input, dut.fir_x_input === fir_x_input ? fir_x_input : 32'hx);

        reload(5, 0, -1, 1'b0);
        reload(92, 1, -1, 1'b0);
        reject(0);
        reject(93);
        reject(127);
        pass_through(8, 16'h1234);
        reload(4, 2, -1, 1'b1);
        reload(8, 0, 2, 1'b1);

        cfg_abort = 1'b1; s_valid_in = 1'b1; s_data_in = 16'h5A5A;
        cyc();
        cfg_abort = 1'b0;
        chk("idle_abort_no_err", cfg_err, 0);
        chk("idle_abort_fwd", fir_x_input, 16'h5A5A);
        s_valid_in = 1'b0;

        for (int r = 0; r < 3; r++) reload($urandom_range(1, 92), 3, -1, 1'($urandom_range(0, 1)));

        cfg_start = 1'b1; cfg_num_taps = 7'd6; s_valid_in = 1'b1;
        cyc();
        cfg_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cfg_coeff_valid = 1'b1; cfg_coeff = 16'h0F00 + 16'(i);
            cyc();
        end
        cfg_coeff_valid = 1'b0;
        cyc();
        cyc();
        chk("pre_rst_flush", fir_valid_in, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", cfg_busy, 0);
        chk("arst_ready", cfg_coeff_ready, 0);
        chk("arst_fir_valid", fir_valid_in, 0);
        chk("arst_addr", coeff_addr, 0);
        chk("arst_wdata", coeff_wdata, 0);
        chk("arst_drop", drop_count, 0);
        chk("arst_pulses", {cfg_done, cfg_err, coeff_we}, 0);
        @(negedge clk) rst = 1'b0;
        s_valid_in = 1'b0;
        cyc();
        chk("post_rst_idle", cfg_busy, 0);
        pass_through(4, 16'h7FFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
